// File: rtl/oled_fb_pkg.sv
// oled_fb_pkg: shared types and geometry helpers for the OLED framebuffer arbiter.
// Provides the FSM state enum, address width and per-mode framebuffer dimensions.
package oled_fb_pkg;

  localparam int ADDR_W = 13;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_CAPT
  } fb_state_e;

  function automatic int fb_width(input int color);
    return (color != 0) ? 96 : 128;
  endfunction

  function automatic int fb_height(input int color);
    return (color != 0) ? 64 : 8;
  endfunction

  function automatic int FB_DEPTH(input int color);
    return fb_width(color) * fb_height(color);
  endfunction

endpackage

// File: rtl/oled_fb_addr.sv
// oled_fb_addr: combinational row*WIDTH+col mapper for display fetches.
// Ports: row (page/row index), col (column index) -> addr (linear pixel address).
import oled_fb_pkg::*;

module oled_fb_addr #(
  parameter int COLOR = 0
) (
  input  logic [5:0]        row,
  input  logic [6:0]        col,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] W = ADDR_W'(fb_width(COLOR));

  assign addr = ADDR_W'(row) * W + ADDR_W'(col);

endmodule

// File: rtl/oled_fb_arbiter.sv
// oled_fb_arbiter: shares one single-port framebuffer RAM between the OLED refresh
// fetch port (always wins) and a pixel-write client that uses every idle RAM cycle.
// Ports: disp_* fetch request/response, wr_* write handshake + drop pulse,
// ram_* registered RAM port, frame_done, swap_req/swap_pending.
// Option: define OLED_FB_DOUBLE_BUFFER_EN for two banks with frame-synchronous swap.
import oled_fb_pkg::*;

module oled_fb_arbiter #(
  parameter int COLOR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_read,
  input  logic [5:0]        disp_row,
  input  logic [6:0]        disp_col,
  output logic [7:0]        disp_data,
  output logic [15:0]       disp_data_rgb,
  output logic              disp_ack,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic              wr_drop,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_bank,
  output logic              ram_we,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  output logic              frame_done,
  input  logic              swap_req,
  output logic              swap_pending
);

  localparam int WIDTH  = fb_width(COLOR);
  localparam int HEIGHT = fb_height(COLOR);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(FB_DEPTH(COLOR));

  fb_state_e         state_q, state_d;
  logic              rd_pending_q, rd_pending_d;
  logic [5:0]        row_q, row_d;
  logic [6:0]        col_q, col_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_bank_q, ram_bank_d;
  logic              ram_we_q, ram_we_d;
  logic [15:0]       ram_wdata_q, ram_wdata_d;
  logic              wr_drop_q, wr_drop_d;
  logic [15:0]       rgb_q, rgb_d;
  logic              capt_q, capt_d;
  logic              capt_last_q, capt_last_d;
  logic              disp_ack_q, disp_ack_d;
  logic              frame_done_q, frame_done_d;
  logic              front_q, front_d;
  logic              swap_pending_q, swap_pending_d;
  logic              back_bank;
  logic [ADDR_W-1:0] disp_addr;

  oled_fb_addr #(
    .COLOR(COLOR)
  ) u_addr (
    .row (row_q),
    .col (col_q),
    .addr(disp_addr)
  );

`ifdef OLED_FB_DOUBLE_BUFFER_EN
  // A swap_req landing in the frame_done cycle is folded in and taken.
  always_comb begin
    front_d        = front_q;
    swap_pending_d = swap_pending_q | swap_req;
    if (frame_done_q && swap_pending_d) begin
      front_d        = ~front_q;
      swap_pending_d = 1'b0;
    end
  end
  assign back_bank = ~front_q;
`else
  logic unused_swap;
  assign unused_swap    = swap_req;
  assign front_d        = 1'b0;
  assign swap_pending_d = 1'b0;
  assign back_bank      = 1'b0;
`endif

  assign wr_ready = !rst && state_q == IDLE && !rd_pending_q;

  always_comb begin
    state_d      = state_q;
    rd_pending_d = rd_pending_q;
    row_d        = row_q;
    col_d        = col_q;
    ram_addr_d   = ram_addr_q;
    ram_bank_d   = ram_bank_q;
    ram_we_d     = 1'b0;
    ram_wdata_d  = ram_wdata_q;
    wr_drop_d    = 1'b0;
    rgb_d        = rgb_q;
    capt_d       = 1'b0;
    capt_last_d  = 1'b0;
    disp_ack_d   = capt_q;
    frame_done_d = capt_last_q;

    if (disp_read && !rd_pending_q && state_q == IDLE) begin
      rd_pending_d = 1'b1;
      row_d        = disp_row;
      col_d        = disp_col;
    end

    unique case (state_q)
      IDLE: begin
        if (rd_pending_q) begin
          // Let a just-issued write finish its RAM cycle first.
          if (!ram_we_q) begin
            ram_addr_d   = disp_addr;
            ram_bank_d   = front_d;
            rd_pending_d = 1'b0;
            state_d      = RD_WAIT;
          end
        end else if (wr_valid) begin
          if ({1'b0, wr_addr} < DEPTH) begin
            ram_addr_d  = wr_addr;
            ram_wdata_d = wr_data;
            ram_bank_d  = back_bank;
            ram_we_d    = 1'b1;
          end else begin
            wr_drop_d = 1'b1;
          end
        end
      end
      RD_WAIT: state_d = RD_CAPT;
      RD_CAPT: begin
        rgb_d       = ram_rdata;
        capt_d      = 1'b1;
        capt_last_d = (row_q == 6'(HEIGHT-1)) &&
                      (col_q == 7'(WIDTH-1));
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      rd_pending_q   <= 1'b0;
      row_q          <= '0;
      col_q          <= '0;
      ram_addr_q     <= '0;
      ram_bank_q     <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_wdata_q    <= '0;
      wr_drop_q      <= 1'b0;
      rgb_q          <= '0;
      capt_q         <= 1'b0;
      capt_last_q    <= 1'b0;
      disp_ack_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      front_q        <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_pending_q   <= rd_pending_d;
      row_q          <= row_d;
      col_q          <= col_d;
      ram_addr_q     <= ram_addr_d;
      ram_bank_q     <= ram_bank_d;
      ram_we_q       <= ram_we_d;
      ram_wdata_q    <= ram_wdata_d;
      wr_drop_q      <= wr_drop_d;
      rgb_q          <= rgb_d;
      capt_q         <= capt_d;
      capt_last_q    <= capt_last_d;
      disp_ack_q     <= disp_ack_d;
      frame_done_q   <= frame_done_d;
      front_q        <= front_d;
      swap_pending_q <= swap_pending_d;
    end
  end

  assign disp_data     = rgb_q[7:0];
  assign disp_data_rgb = rgb_q;
  assign disp_ack      = disp_ack_q;
  assign wr_drop       = wr_drop_q;
  assign ram_addr      = ram_addr_q;
  assign ram_bank      = ram_bank_q;
  assign ram_we        = ram_we_q;
  assign ram_wdata     = ram_wdata_q;
  assign frame_done    = frame_done_q;
  assign swap_pending  = swap_pending_q;

endmodule

// File: tb/tb_oled_fb_arbiter.sv
// tb_oled_fb_arbiter: scoreboard bench for a mono and a color arbiter instance,
// each attached to its own single-port RAM model.
module tb_oled_fb_arbiter;

`ifdef OLED_FB_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]        disp_read;
  logic [1:0][5:0]   disp_row;
  logic [1:0][6:0]   disp_col;
  logic [1:0][7:0]   disp_data;
  logic [1:0][15:0]  disp_data_rgb;
  logic [1:0]        disp_ack;
  logic [1:0]        wr_valid;
  logic [1:0]        wr_ready;
  logic [1:0][12:0]  wr_addr;
  logic [1:0][15:0]  wr_data;
  logic [1:0]        wr_drop;
  logic [1:0][12:0]  ram_addr;
  logic [1:0]        ram_bank;
  logic [1:0]        ram_we;
  logic [1:0][15:0]  ram_wdata;
  logic [15:0]       ram_rdata0, ram_rdata1;
  logic [1:0]        frame_done;
  logic [1:0]        swap_req;
  logic [1:0]        swap_pending;

  oled_fb_arbiter #(.COLOR(0)) u_mono (
    .clk(clk), .rst(rst),
    .disp_read(disp_read[0]), .disp_row(disp_row[0]), .disp_col(disp_col[0]),
    .disp_data(disp_data[0]), .disp_data_rgb(disp_data_rgb[0]), .disp_ack(disp_ack[0]),
    .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .wr_drop(wr_drop[0]),
    .ram_addr(ram_addr[0]), .ram_bank(ram_bank[0]), .ram_we(ram_we[0]),
    .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata0),
    .frame_done(frame_done[0]), .swap_req(swap_req[0]), .swap_pending(swap_pending[0])
  );

  oled_fb_arbiter #(.COLOR(1)) u_color (
    .clk(clk), .rst(rst),
    .disp_read(disp_read[1]), .disp_row(disp_row[1]), .disp_col(disp_col[1]),
    .disp_data(disp_data[1]), .disp_data_rgb(disp_data_rgb[1]), .disp_ack(disp_ack[1]),
    .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .wr_drop(wr_drop[1]),
    .ram_addr(ram_addr[1]), .ram_bank(ram_bank[1]), .ram_we(ram_we[1]),
    .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata1),
    .frame_done(frame_done[1]), .swap_req(swap_req[1]), .swap_pending(swap_pending[1])
  );

  logic [15:0] mem0 [16384];
  logic [15:0] mem1 [16384];

  always @(posedge clk) begin
    if (ram_we[0]) mem0[{ram_bank[0], ram_addr[0]}] <= ram_wdata[0];
    ram_rdata0 <= mem0[{ram_bank[0], ram_addr[0]}];
  end

  always @(posedge clk) begin
    if (ram_we[1]) mem1[{ram_bank[1], ram_addr[1]}] <= ram_wdata[1];
    ram_rdata1 <= mem1[{ram_bank[1], ram_addr[1]}];
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem0[i] <= '0;
      mem1[i] <= '0;
    end
    mem0[130]  <= 16'h00A5;
    mem0[1023] <= 16'h0077;
    mem1[6142] <= 16'hCAFE;
    mem1[6143] <= 16'hBEEF;
  end

  typedef struct { int k; int cyc; logic [15:0] data; bit fd; } rd_exp_t;
  typedef struct { int k; int cyc; logic bank; logic [12:0] addr; logic [15:0] data; } wr_exp_t;
  typedef struct { int k; int cyc; } dr_exp_t;

  rd_exp_t rq[$];
  wr_exp_t wq[$];
  dr_exp_t dq[$];

  int checks = 0;
  int errors = 0;
  int ack_cnt0 = 0;
  int ack_cnt1 = 0;
  bit front1 = 1'b0;

  task automatic chk(input bit ok, input string name, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, msg);
    end
  endtask

  function automatic logic back_of(input int k);
    logic f;
    f = (k == 1) ? front1 : 1'b0;
    return DB ? ~f : 1'b0;
  endfunction

  rd_exp_t mr;
  wr_exp_t mw;
  dr_exp_t md;

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (disp_ack[k]) begin
          if (k == 0) ack_cnt0++; else ack_cnt1++;
          if (rq.size() == 0) begin
            chk(1'b0, "ack_unexpected",
                $sformatf("inst %0d ack at cyc %0d, required none", k, cyc));
          end else begin
            mr = rq.pop_front();
            chk(mr.k == k && mr.cyc == cyc && disp_data_rgb[k] == mr.data &&
                disp_data[k] == mr.data[7:0] && frame_done[k] == mr.fd, "ack",
                $sformatf("inst %0d cyc %0d rgb %h fd %0b, required inst %0d cyc %0d rgb %h fd %0b",
                          k, cyc, disp_data_rgb[k], frame_done[k], mr.k, mr.cyc, mr.data, mr.fd));
          end
        end else if (frame_done[k]) begin
          chk(1'b0, "frame_done_stray",
              $sformatf("inst %0d frame_done without ack at cyc %0d, required 0", k, cyc));
        end
        if (ram_we[k]) begin
          if (wq.size() == 0) begin
            chk(1'b0, "we_unexpected",
                $sformatf("inst %0d ram_we at cyc %0d addr %0d, required 0", k, cyc, ram_addr[k]));
          end else begin
            mw = wq.pop_front();
            chk(mw.k == k && mw.cyc == cyc && ram_bank[k] == mw.bank &&
                ram_addr[k] == mw.addr && ram_wdata[k] == mw.data, "ram_write",
                $sformatf("inst %0d cyc %0d bank %0b addr %0d data %h, required inst %0d cyc %0d bank %0b addr %0d data %h",
                          k, cyc, ram_bank[k], ram_addr[k], ram_wdata[k],
                          mw.k, mw.cyc, mw.bank, mw.addr, mw.data));
          end
        end
        if (wr_drop[k]) begin
          if (dq.size() == 0) begin
            chk(1'b0, "drop_unexpected",
                $sformatf("inst %0d wr_drop at cyc %0d, required 0", k, cyc));
          end else begin
            md = dq.pop_front();
            chk(md.k == k && md.cyc == cyc, "wr_drop",
                $sformatf("inst %0d cyc %0d, required inst %0d cyc %0d", k, cyc, md.k, md.cyc));
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input int k, input string name);
    chk({disp_data[k], disp_data_rgb[k], disp_ack[k], wr_drop[k], ram_addr[k],
         ram_bank[k], ram_we[k], ram_wdata[k], frame_done[k], swap_pending[k]} == '0,
        name,
        $sformatf("inst %0d ack %0b we %0b addr %0d bank %0b rgb %h wdata %h sp %0b, required all 0",
                  k, disp_ack[k], ram_we[k], ram_addr[k], ram_bank[k],
                  disp_data_rgb[k], ram_wdata[k], swap_pending[k]));
  endtask

  // Call at #1 after a posedge; leaves wr_valid asserted for the caller.
  task automatic wr_beat(input int k, input logic [12:0] a, input logic [15:0] d,
                         input bit drop);
    wr_valid[k] = 1'b1;
    wr_addr[k]  = a;
    wr_data[k]  = d;
    chk(wr_ready[k] == 1'b1, "wr_ready",
        $sformatf("inst %0d wr_ready %0b, required 1", k, wr_ready[k]));
    if (drop) dq.push_back('{k, cyc + 1});
    else      wq.push_back('{k, cyc + 1, back_of(k), a, d});
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int k, input logic [5:0] r, input logic [6:0] c,
                    input logic [12:0] ea, input logic [15:0] ed, input bit fd,
                    input bit wr, input logic [12:0] wa, input logic [15:0] wd);
    int  e0;
    logic fb;
    @(posedge clk);
    #1;
    fb = (k == 1) ? front1 : 1'b0;
    disp_read[k] = 1'b1;
    disp_row[k]  = r;
    disp_col[k]  = c;
    e0 = cyc + 1;
    if (wr) begin
      wr_valid[k] = 1'b1;
      wr_addr[k]  = wa;
      wr_data[k]  = wd;
      wq.push_back('{k, e0, back_of(k), wa, wd});
    end
    rq.push_back('{k, e0 + 4 + (wr ? 1 : 0), ed, fd});
    @(posedge clk);
    #1;
    disp_read[k] = 1'b0;
    wr_valid[k]  = 1'b0;
    chk(wr_ready[k] == 1'b0, "rd_blocks_wr",
        $sformatf("inst %0d wr_ready %0b, required 0", k, wr_ready[k]));
    if (wr) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk(ram_addr[k] == ea && ram_bank[k] == fb && ram_we[k] == 1'b0, "rd_addr",
        $sformatf("inst %0d addr %0d bank %0b we %0b, required addr %0d bank %0b we 0",
                  k, ram_addr[k], ram_bank[k], ram_we[k], ea, fb));
    idle(6);
  endtask

  initial begin
    int a;
    rst       = 1'b1;
    disp_read = '0;
    disp_row  = '0;
    disp_col  = '0;
    wr_valid  = '0;
    wr_addr   = '0;
    wr_data   = '0;
    swap_req  = '0;
    idle(3);
    for (int k = 0; k < 2; k++) begin
      chk(wr_ready[k] == 1'b0, "reset_wr_ready",
          $sformatf("inst %0d wr_ready %0b, required 0", k, wr_ready[k]));
      chk_zero(k, "reset_outputs");
    end
    rst = 1'b0;
    idle(1);
    for (int k = 0; k < 2; k++)
      chk(wr_ready[k] == 1'b1, "idle_wr_ready",
          $sformatf("inst %0d wr_ready %0b, required 1", k, wr_ready[k]));

    // Mono: row 1 col 2 -> 130
    rd(0, 6'd1, 7'd2, 13'd130, 16'h00A5, 1'b0, 1'b0, '0, '0);

    wr_beat(0, 13'd200, 16'h5A3C, 1'b0);
    wr_valid[0] = 1'b0;
    idle(2);

    wr_beat(0, 13'd10, 16'h0010, 1'b0);
    wr_beat(0, 13'd11, 16'h0011, 1'b0);
    wr_valid[0] = 1'b0;
    idle(2);

    wr_beat(0, 13'd1024, 16'hDEAD, 1'b1);
    wr_valid[0] = 1'b0;
    idle(2);

    // Collision plus mono frame end: row 7 col 127 -> 1023
    rd(0, 6'd7, 7'd127, 13'd1023, 16'h0077, 1'b1, 1'b1, 13'd5, 16'h1234);
    chk(swap_pending[0] == 1'b0, "mono_swap_pending",
        $sformatf("swap_pending %0b, required 0", swap_pending[0]));

    // Color: out of range then last pixel
    wr_beat(1, 13'd6144, 16'h0BAD, 1'b1);
    wr_beat(1, 13'd6143, 16'hF00D, 1'b0);
    wr_valid[1] = 1'b0;
    idle(2);

    rd(1, 6'd63, 7'd94, 13'd6142, 16'hCAFE, 1'b0, 1'b0, '0, '0);

    swap_req[1] = 1'b1;
    idle(1);
    swap_req[1] = 1'b0;
    chk(swap_pending[1] == DB, "swap_pending_set",
        $sformatf("swap_pending %0b, required %0b", swap_pending[1], DB));

    rd(1, 6'd63, 7'd95, 13'd6143, DB ? 16'hBEEF : 16'hF00D, 1'b1, 1'b0, '0, '0);
    if (DB) front1 = 1'b1;
    chk(swap_pending[1] == 1'b0, "swap_pending_clear",
        $sformatf("swap_pending %0b, required 0", swap_pending[1]));

    rd(1, 6'd63, 7'd95, 13'd6143, 16'hF00D, 1'b1, 1'b0, '0, '0);

    wr_beat(1, 13'd0, 16'h0001, 1'b0);
    wr_valid[1] = 1'b0;
    idle(2);

    // Reset while the color instance sits in RD_WAIT
    @(posedge clk);
    #1;
    disp_read[1] = 1'b1;
    disp_row[1]  = 6'd0;
    disp_col[1]  = 7'd0;
    idle(1);
    disp_read[1] = 1'b0;
    idle(1);
    a = ack_cnt1;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    front1 = 1'b0;
    idle(8);
    chk(ack_cnt1 == a, "reset_no_ack",
        $sformatf("acks %0d, required %0d", ack_cnt1, a));
    chk(wr_ready[1] == 1'b1, "post_reset_wr_ready",
        $sformatf("wr_ready %0b, required 1", wr_ready[1]));
    chk_zero(1, "post_reset_outputs");

    idle(4);
    chk(rq.size() == 0, "rd_queue_empty",
        $sformatf("%0d acks outstanding, required 0", rq.size()));
    chk(wq.size() == 0, "wr_queue_empty",
        $sformatf("%0d writes outstanding, required 0", wq.size()));
    chk(dq.size() == 0, "drop_queue_empty",
        $sformatf("%0d drops outstanding, required 0", dq.size()));
    chk(ack_cnt0 == 2, "mono_ack_count",
        $sformatf("acks %0d, required 2", ack_cnt0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oled_fb_arbiter.md
# oled_fb_arbiter

- Shares one single-port synchronous framebuffer RAM between two masters: the OLED refresh controller's pixel-fetch interface and a generic pixel-write client.
- Sits between the OLED controller's read port and the framebuffer RAM.
- Refresh reads always take priority. The write client uses every idle RAM cycle.
- Optionally double-buffers the framebuffer, with frame-synchronous bank swap.

## Interface
Parameters:
- COLOR, 0, 0 = mono 128x8 pages, 8-bit strips; 1 = color 96x64, 16-bit RGB565.
- WIDTH, derived: COLOR ? 96 : 128. Not overridable.
- HEIGHT, derived: COLOR ? 64 : 8. Not overridable.

Ports:
- The clock is `clk`. Reset is asynchronous and active-high.
- clk  in  1  system clock; also the OLED SPI clock domain.
- rst  in  1  asynchronous, active-high reset.
- disp_read  in  1  single-cycle fetch request from the OLED controller.
- disp_row  in  6  row/page index, valid with disp_read.
- disp_col  in  7  column index, valid with disp_read.
- disp_data  out  8  mono strip (ram_rdata[7:0]).
- disp_data_rgb  out  16  color pixel (ram_rdata).
- disp_ack  out  1  one-cycle pulse: disp_data/disp_data_rgb are valid.
- wr_valid  in  1  write request.
- wr_ready  out  1  arbiter can accept a write this cycle.
- wr_addr  in  13  linear pixel address.
- wr_data  in  16  pixel data; mono uses [7:0].
- wr_drop  out  1  pulse: an accepted write was out of range and discarded.
- ram_addr  out  13  registered RAM address.
- ram_bank  out  1  registered RAM bank select (address MSB).
- ram_we  out  1  registered write enable.
- ram_wdata  out  16  registered write data.
- ram_rdata  in  16  RAM read data, valid 1 cycle after the address is presented.
- frame_done  out  1  pulse coincident with the ack of the last pixel.
- swap_req  in  1  pulse: request a bank swap.
- swap_pending  out  1  swap requested and not yet taken.

## Operation
- **Linear address:** disp_row*WIDTH + disp_col. Range is 0..1023 for mono and 0..6143 for color. Computed in 13 bits, no overflow.
- **Read latch:**
  - disp_read is latched into rd_pending with row/col captured.
  - A disp_read arriving while rd_pending is set, or while the FSM is not in IDLE, is discarded.
- **FSM states:** IDLE, RD_WAIT, RD_CAPT.
  - IDLE with rd_pending set: drive ram_addr = display address, ram_we=0, ram_bank=front. Clear rd_pending and go to RD_WAIT.
  - IDLE with rd_pending clear: wr_ready=1. On wr_valid, register ram_addr/ram_wdata/ram_we=1 (ram_bank=back). If wr_addr >= WIDTH*HEIGHT, ram_we stays 0 and wr_drop pulses instead.
  - RD_WAIT: RAM access cycle; go to RD_CAPT.
  - RD_CAPT: register ram_rdata into disp_data/disp_data_rgb, pulse disp_ack next cycle, return to IDLE.
- **wr_ready:** = !rst && state==IDLE && !rd_pending. It never depends on wr_valid.
- **Simultaneous disp_read and wr_valid in IDLE with rd_pending clear:** the write is accepted that cycle and the read issues next cycle.
- **frame_done:** asserted with disp_ack when the captured row/col equal HEIGHT-1/WIDTH-1.
- ram_we is high only for the single cycle following a write handshake.

## Timing
- **Reset values:** all outputs 0 (wr_ready forced 0 while rst=1). State=IDLE, rd_pending=0, front bank=0.
- **Read latency:** disp_read sampled at edge E0 → RAM address at E1 → RD_CAPT at E3 → disp_ack high E4..E5 (exactly one cycle).
- **Worst-case read latency with a colliding write:** one extra cycle.
- **Write latency:** handshake at edge E0 → ram_we/addr/data valid E0..E1.
- **Throughput:** one write per cycle while no read is pending. A display read blocks writes for 3 cycles.
- **Reset mid-operation:** pending read and ack are dropped, with no partial ack. rst must be asserted together with the OLED controller restart.

## Configuration
Macro `OLED_FB_DOUBLE_BUFFER_EN`:
- **Defined:**
  - Two banks. Display reads use the front bank; writes use the back bank.
  - swap_req sets swap_pending.
  - At a frame_done cycle with swap_pending set, the front bank toggles and swap_pending clears in the same edge.
  - If swap_req and frame_done coincide, the swap is taken.
- **Not defined:**
  - Single bank: ram_bank is constant 0 for all accesses.
  - swap_req is ignored and swap_pending is constant 0.

## Structure
- **Package oled_fb_pkg:** FSM state enum, ADDR_W=13, fb_width(color)/fb_height(color) functions, FB_DEPTH(color).
- **Sub-module oled_fb_addr:** combinational row*WIDTH+col mapper, parameterised by COLOR. It is used for the display address.

## Test plan
- **Mono read:** preload addr 130 = 8'hA5; pulse disp_read with row=1, col=2 → disp_ack at E4 with disp_data=8'hA5.
- **Collision:** in IDLE, disp_read and wr_valid (addr 5, data 16'h1234) in the same cycle → write accepted at E0, ram_we at E1, read ack at E5.
- **Out of range:** COLOR=1, write to addr 6144 → wr_drop pulse, ram_we stays 0. Write to 6143 → ram_we=1, ram_addr=6143.
- **Frame end:** read row=63, col=95 (COLOR=1) → frame_done coincident with disp_ack. Read row=63, col=94 → frame_done stays 0.
- **Double buffer (macro defined):** swap_req mid-frame → swap_pending=1. At frame_done, the front bank toggles, swap_pending=0, and the next display ram_bank=1.
- **Reset mid-read:** rst in RD_WAIT → no disp_ack ever. After release, wr_ready=1 and all outputs are 0.
